// File: rtl/quadec_pkg.sv
// quadec_pkg: shared types and helpers for the quadrature decoder.
//   phase_t     - 2-bit encoder phase, packed as {B, A}
//   step_t      - classification of one accepted phase change
//   fwd_succ()  - forward successor in the Gray sequence 00->01->11->10->00
//   classify()  - classify a change from prev to cur as NONE/FWD/REV/ILLEGAL
package quadec_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  function automatic phase_t fwd_succ(input phase_t p);
    phase_t s;
    case (p)
      PH_00:   s = PH_01;
      PH_01:   s = PH_11;
      PH_11:   s = PH_10;
      default: s = PH_00;
    endcase
    return s;
  endfunction

  // Only one bit may change between neighbours of the Gray sequence; a change
  // that is neither the forward nor the reverse neighbour flipped both bits.
  function automatic step_t classify(input phase_t prev, input phase_t cur);
    step_t k;
    if (cur == prev)                k = STEP_NONE;
    else if (cur == fwd_succ(prev)) k = STEP_FWD;
    else if (prev == fwd_succ(cur)) k = STEP_REV;
    else                            k = STEP_ILLEGAL;
    return k;
  endfunction

endpackage

// File: rtl/quadec_v_if.sv
// quadec_v_if: pin-side and result-side signals of the quadrature decoder.
//   A, B         encoder phases (asynchronous to the decoder clock)
//   CLEAR        synchronous clear of COUNT / ERROR / ERR_CNT
//   COUNT        signed 32-bit position
//   STEP, DIR    one-cycle step pulse and direction of the last step
//   SPEED        signed net steps of the last completed window
//   SPEED_VALID  one-cycle pulse when SPEED updates
//   ERROR        sticky illegal-transition flag
//   ERR_CNT      saturating illegal-transition count
// master: the side driving the pins (encoder / bench); slave: the decoder.
interface quadec_v_if;

  logic        A;
  logic        B;
  logic        CLEAR;
  logic [31:0] COUNT;
  logic        STEP;
  logic        DIR;
  logic [31:0] SPEED;
  logic        SPEED_VALID;
  logic        ERROR;
  logic [7:0]  ERR_CNT;

  modport master (
    output A, B, CLEAR,
    input  COUNT, STEP, DIR, SPEED, SPEED_VALID, ERROR, ERR_CNT
  );

  modport slave (
    input  A, B, CLEAR,
    output COUNT, STEP, DIR, SPEED, SPEED_VALID, ERROR, ERR_CNT
  );

endinterface

// File: rtl/quad_filter_v.sv
// quad_filter_v: 2-flop synchronizer plus run-length glitch filter for {B,A}.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   raw       unsynchronized {B,A}
//   filt      filtered phase, resets to 00
//   filt_upd  one-cycle pulse each time filt is (re)loaded after a stable run
// The synchronized value must stay unchanged for FILTER_LEN consecutive edges
// after it first appears before it is accepted; any change restarts the run.
module quad_filter_v
  import quadec_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  phase_t raw,
  output phase_t filt,
  output logic   filt_upd
);

  localparam logic [7:0] RUN_MAX = 8'(FILTER_LEN);

  phase_t     sync1_reg;
  phase_t     sync2_reg;
  phase_t     filt_reg;
  logic       upd_reg;
  logic [7:0] run_reg;
  logic [7:0] run_next;

  // run_reg counts how many edges sync2 has been reloaded with an unchanged
  // value; it saturates at FILTER_LEN so a long stable input pulses only once.
  always_comb begin
    run_next = run_reg;
    if (sync1_reg != sync2_reg)  run_next = 8'd0;
    else if (run_reg != RUN_MAX) run_next = run_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= PH_00;
      sync2_reg <= PH_00;
      filt_reg  <= PH_00;
      upd_reg   <= 1'b0;
      run_reg   <= 8'd0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      run_reg   <= run_next;
      upd_reg   <= 1'b0;
      if (run_next == RUN_MAX && run_reg != RUN_MAX) begin
        filt_reg <= sync2_reg;
        upd_reg  <= 1'b1;
      end
    end
  end

  assign filt     = filt_reg;
  assign filt_upd = upd_reg;

endmodule

// File: rtl/quadec_v.sv
// quadec_v: quadrature decoder top level.
//   CLOCK    system clock, the only clock
//   RESET_N  asynchronous active-low reset
//   bus      quadec_v_if.slave: A/B pins and CLEAR in; COUNT, STEP, DIR,
//            SPEED, SPEED_VALID, ERROR, ERR_CNT out (all registered)
// Parameters: FILTER_LEN (1..255) stable edges before a phase is accepted,
// WINDOW (>=2) speed measurement window in clock cycles.
module quadec_v
  import quadec_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned WINDOW     = 50000
) (
  input logic       CLOCK,
  input logic       RESET_N,
  quadec_v_if.slave bus
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  phase_t            filt;
  logic              filt_upd;

  logic [0:0]        state_reg;
  phase_t            prev_reg;
  logic [31:0]       count_reg;
  logic              step_reg;
  logic              dir_reg;
  logic [31:0]       speed_reg;
  logic              speed_valid_reg;
  logic              error_reg;
  logic [7:0]        err_cnt_reg;
  logic [WIN_W-1:0]  win_reg;
  logic [31:0]       acc_reg;

  step_t             step_kind;
  logic              is_step;
  logic              is_illegal;
  logic [31:0]       step_delta;
  logic              win_last;

  quad_filter_v #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .raw      ({bus.B, bus.A}),
    .filt     (filt),
    .filt_upd (filt_upd)
  );

  // In INIT the first filter update only seeds prev_reg, so pins that are
  // already non-00 at reset release never produce a step.
  always_comb begin
    step_kind = STEP_NONE;
    if (filt_upd && state_reg == ST_RUN) step_kind = classify(prev_reg, filt);
    is_step    = (step_kind == STEP_FWD) || (step_kind == STEP_REV);
    is_illegal = (step_kind == STEP_ILLEGAL);
    step_delta = 32'd0;
    if (step_kind == STEP_FWD) step_delta = 32'd1;
    if (step_kind == STEP_REV) step_delta = 32'hFFFF_FFFF;
    win_last   = (win_reg == WIN_LAST);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg       <= ST_INIT;
      prev_reg        <= PH_00;
      count_reg       <= 32'd0;
      step_reg        <= 1'b0;
      dir_reg         <= 1'b1;
      speed_reg       <= 32'd0;
      speed_valid_reg <= 1'b0;
      error_reg       <= 1'b0;
      err_cnt_reg     <= 8'd0;
      win_reg         <= '0;
      acc_reg         <= 32'd0;
    end else begin
      if (filt_upd) begin
        state_reg <= ST_RUN;
        prev_reg  <= filt;
      end

      step_reg <= is_step;
      if (is_step) dir_reg <= (step_kind == STEP_FWD);

      // CLEAR takes priority over a step or illegal event in the same cycle.
      if (bus.CLEAR) begin
        count_reg   <= 32'd0;
        error_reg   <= 1'b0;
        err_cnt_reg <= 8'd0;
      end else begin
        count_reg <= count_reg + step_delta;
        if (is_illegal) begin
          error_reg <= 1'b1;
          if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
      end

      // The step landing on the last window cycle belongs to the closing window.
      speed_valid_reg <= win_last;
      if (win_last) begin
        win_reg   <= '0;
        speed_reg <= acc_reg + step_delta;
        acc_reg   <= 32'd0;
      end else begin
        win_reg <= win_reg + 1'b1;
        acc_reg <= acc_reg + step_delta;
      end
    end
  end

  assign bus.COUNT       = count_reg;
  assign bus.STEP        = step_reg;
  assign bus.DIR         = dir_reg;
  assign bus.SPEED       = speed_reg;
  assign bus.SPEED_VALID = speed_valid_reg;
  assign bus.ERROR       = error_reg;
  assign bus.ERR_CNT     = err_cnt_reg;

endmodule

// File: tb/tb_quadec_v.sv
// tb_quadec_v: directed + randomized bench for quadec_v. The reference model
// treats each pin change held long enough as an event that lands a fixed
// number of edges later; its kind comes from the distance between the two
// phases around the 00,01,11,10 ring. Outputs are compared every cycle.
module tb_quadec_v;

  localparam int F   = 4;
  localparam int W   = 100;
  localparam int LAT = F + 3;   // drive after edge n -> visible after edge n+LAT

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b1;

  quadec_v_if bus ();

  quadec_v #(
    .FILTER_LEN (F),
    .WINDOW     (W)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int due;
    int kind;   // 1 forward, -1 reverse, 2 illegal
  } ev_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = -1;
  ev_t         evq[$];
  logic [1:0]  m_ph;
  logic [31:0] m_count, m_speed, m_acc;
  logic        m_dir, m_err;
  int          m_errcnt;
  int          step_seen, valid_seen;
  logic [31:0] last_speed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ph_pos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_count  = 32'd0;
    m_speed  = 32'd0;
    m_acc    = 32'd0;
    m_dir    = 1'b1;
    m_err    = 1'b0;
    m_errcnt = 0;
    evq.delete();
  endtask

  task automatic tick();
    logic        clr;
    logic        exp_step, exp_valid;
    logic [31:0] delta;
    ev_t         ev;
    clr = bus.CLEAR;
    @(posedge CLOCK);
    #1;
    cyc++;
    exp_step = 1'b0;
    delta    = 32'd0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      ev = evq.pop_front();
      if (ev.kind == 2) begin
        m_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end else begin
        exp_step = 1'b1;
        m_dir    = (ev.kind == 1);
        delta    = (ev.kind == 1) ? 32'd1 : 32'hFFFF_FFFF;
        m_count  = m_count + delta;
        m_acc    = m_acc + delta;
      end
    end
    if (clr) begin
      m_count  = 32'd0;
      m_err    = 1'b0;
      m_errcnt = 0;
    end
    exp_valid = ((cyc % W) == W - 1);
    if (exp_valid) begin
      m_speed = m_acc;
      m_acc   = 32'd0;
    end
    chk("step",        32'(bus.STEP),        32'(exp_step));
    chk("count",       bus.COUNT,            m_count);
    chk("dir",         32'(bus.DIR),         32'(m_dir));
    chk("error",       32'(bus.ERROR),       32'(m_err));
    chk("err_cnt",     32'(bus.ERR_CNT),     32'(m_errcnt));
    chk("speed",       bus.SPEED,            m_speed);
    chk("speed_valid", 32'(bus.SPEED_VALID), 32'(exp_valid));
    if (bus.STEP === 1'b1) step_seen++;
    if (bus.SPEED_VALID === 1'b1) begin
      valid_seen++;
      last_speed = bus.SPEED;
    end
  endtask

  // Drive pins; schedule a model event only if the value is held long enough.
  task automatic drive(input logic [1:0] v, input int hold);
    int  d;
    ev_t ev;
    bus.B = v[1];
    bus.A = v[0];
    if (hold >= F + 1 && v != m_ph) begin
      d       = (ph_pos(v) - ph_pos(m_ph) + 4) % 4;
      ev.due  = cyc + LAT;
      ev.kind = (d == 1) ? 1 : ((d == 3) ? -1 : 2);
      evq.push_back(ev);
      m_ph = v;
    end
  endtask

  task automatic set_pins(input logic [1:0] v, input int hold);
    drive(v, hold);
    repeat (hold) tick();
  endtask

  task automatic pulse_clear();
    bus.CLEAR = 1'b1;
    tick();
    bus.CLEAR = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] pins, input bit async_chk);
    bus.B     = pins[1];
    bus.A     = pins[0];
    bus.CLEAR = 1'b0;
    RESET_N   = 1'b0;
    #2;
    if (async_chk) begin
      chk("async_count", bus.COUNT, 32'd0);
      chk("async_speed", bus.SPEED, 32'd0);
    end
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_count",       bus.COUNT,            32'd0);
    chk("rst_step",        32'(bus.STEP),        32'd0);
    chk("rst_dir",         32'(bus.DIR),         32'd1);
    chk("rst_speed",       bus.SPEED,            32'd0);
    chk("rst_speed_valid", 32'(bus.SPEED_VALID), 32'd0);
    chk("rst_error",       32'(bus.ERROR),       32'd0);
    chk("rst_err_cnt",     32'(bus.ERR_CNT),     32'd0);
    model_reset();
    m_ph    = pins;
    cyc     = -1;
    RESET_N = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    int         r;
    bus.A = 1'b0; bus.B = 1'b0; bus.CLEAR = 1'b0;
    step_seen = 0; valid_seen = 0; last_speed = 32'd0;

    // Reset with pins 00, then forward sweep.
    do_reset(2'b00, 1'b0);
    step_seen = 0;
    for (int k = 0; k < 10; k++) begin
      set_pins(2'b01, 8); set_pins(2'b11, 8); set_pins(2'b10, 8); set_pins(2'b00, 8);
    end
    repeat (8) tick();
    chk("fwd_count", bus.COUNT, 32'd40);
    chk("fwd_steps", 32'(step_seen), 32'd40);
    chk("fwd_dir", 32'(bus.DIR), 32'd1);

    // Reverse through zero, then forward again.
    pulse_clear();
    set_pins(2'b10, 8); set_pins(2'b11, 8); set_pins(2'b01, 8);
    chk("rev_count", bus.COUNT, 32'hFFFF_FFFD);
    chk("rev_dir", 32'(bus.DIR), 32'd0);
    set_pins(2'b11, 8); set_pins(2'b10, 8); set_pins(2'b00, 8);
    set_pins(2'b01, 8); set_pins(2'b11, 8);
    chk("wrap_count", bus.COUNT, 32'd2);

    // Short A pulse is filtered out.
    step_seen = 0;
    set_pins(2'b10, 3);
    set_pins(2'b11, 8);
    chk("glitch_steps", 32'(step_seen), 32'd0);
    chk("glitch_count", bus.COUNT, 32'd2);

    // Illegal jump 00->11, then many illegal jumps to saturate ERR_CNT.
    set_pins(2'b10, 8); set_pins(2'b00, 8);
    set_pins(2'b11, 8);
    chk("ill_error", 32'(bus.ERROR), 32'd1);
    chk("ill_err_cnt", 32'(bus.ERR_CNT), 32'd1);
    chk("ill_count", bus.COUNT, 32'd4);
    for (int k = 0; k < 300; k++) set_pins((k % 2 == 0) ? 2'b00 : 2'b11, F + 1);
    repeat (8) tick();
    chk("sat_err_cnt", 32'(bus.ERR_CNT), 32'd255);
    chk("sat_count", bus.COUNT, 32'd4);

    // Randomized pins, glitches and clears against the model.
    pulse_clear();
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      v = 2'($urandom_range(0, 3));
      if (r < 2) begin
        set_pins(v, $urandom_range(1, F));
        set_pins(m_ph, $urandom_range(F + 1, F + 4));
      end else if (r == 2) begin
        pulse_clear();
      end else begin
        set_pins(v, $urandom_range(F + 1, F + 8));
      end
    end
    repeat (8) tick();

    // Speed: one forward transition every 10 cycles; one step coincides with CLEAR.
    valid_seen = 0;
    for (int k = 0; k < 30; k++) begin
      v = (m_ph == 2'b00) ? 2'b01 : (m_ph == 2'b01) ? 2'b11 : (m_ph == 2'b11) ? 2'b10 : 2'b00;
      if (k == 20) begin
        drive(v, 10);
        repeat (LAT - 1) tick();
        bus.CLEAR = 1'b1;
        tick();
        bus.CLEAR = 1'b0;
        chk("clr_step_count", bus.COUNT, 32'd0);
        chk("clr_step_pulse", 32'(bus.STEP), 32'd1);
        repeat (10 - LAT) tick();
      end else begin
        set_pins(v, 10);
      end
    end
    chk("speed_value", last_speed, 32'd10);
    chk("speed_windows", 32'(valid_seen), 32'd3);

    // Mid-operation reset with pins at 11: no seeding step, then 11->10 counts +1.
    step_seen = 0;
    do_reset(2'b11, 1'b1);
    chk("seed_count", bus.COUNT, 32'd0);
    chk("seed_steps", 32'(step_seen), 32'd0);
    set_pins(2'b10, 8);
    chk("seed_next_count", bus.COUNT, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quadec_v.md
# quadec_v

Quadrature decoder: the receiving end of the A/B encoder interface produced by the motor simulator and by real motor encoders. It synchronizes and glitch-filters A/B, decodes every legal transition into a ±1 step on a 32-bit signed position counter, flags illegal double transitions, and reports a signed speed (net steps per fixed window). It sits between the encoder pins and the PID controller's position and speed inputs.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized samples required before a new A/B value is accepted; range 1..255.
- WINDOW, 50000: speed measurement window in CLOCK cycles (1 ms at 50 MHz); minimum 2.
- CLOCK  in  1  system clock (50 MHz); the only clock.
- RESET_N  in  1  reset; asynchronous and active-low.
- A  in  1  encoder phase A; asynchronous to CLOCK.
- B  in  1  encoder phase B; asynchronous to CLOCK.
- CLEAR  in  1  synchronous; zeroes COUNT, ERROR and ERR_CNT.
- COUNT  out  32  signed position; wraps modulo 2^32.
- STEP  out  1  one-cycle pulse on each accepted legal transition.
- DIR  out  1  direction of the last step: 1 forward, 0 reverse.
- SPEED  out  32  signed net step count of the last completed window.
- SPEED_VALID  out  1  one-cycle pulse when SPEED updates.
- ERROR  out  1  sticky; set on an illegal transition.
- ERR_CNT  out  8  illegal transitions; saturates at 255.

## Operation
- Sync: 2-flop synchronizer on {B,A}, reset to 00.
- Filter: filt takes the synced value after it has been identical on FILTER_LEN consecutive edges. Any change restarts the run. filt resets to 00.
- Forward sequence of {B,A} is 00→01→11→10→00, giving +1. The reverse order gives −1. Positive motor power on the simulator therefore counts up.
- Decode FSM states:
  - INIT (reset state): on the first filt update after reset, load prev from filt, emit no step, and go to RUN. This prevents a spurious step when the pins are non-00 at reset.
  - RUN: on each filt change, compare filt with prev and then set prev to filt.
    - Legal change: COUNT ±1, STEP=1, DIR updated.
    - Both bits changed: no count, ERROR=1, ERR_CNT+1 (saturating), prev still updated.
- COUNT arithmetic is two's complement: 0x7FFFFFFF +1 → 0x80000000, and 0 −1 → 0xFFFFFFFF.
- Speed: a window counter runs 0..WINDOW-1. An accumulator sums the steps.
  - On the cycle the counter equals WINDOW-1: SPEED ← accumulator plus that cycle's step, the accumulator clears, and SPEED_VALID=1.
  - The accumulator is 32-bit and wraps.
- CLEAR:
  - Zeroes COUNT, ERROR and ERR_CNT. CLEAR wins over a simultaneous step, so COUNT=0 next cycle.
  - STEP/DIR still reflect that step.
  - Does not affect FSM state, the speed window or the accumulator.

## Timing
- Reset values: COUNT=0, STEP=0, DIR=1, SPEED=0, SPEED_VALID=0, ERROR=0, ERR_CNT=0, FSM=INIT, window counter=0.
- Latency: a pin change present before edge 0 is captured at edge 0, synced at edge 1, filtered at edge 1+FILTER_LEN. STEP/COUNT are visible after edge 2+FILTER_LEN (edge 6 at the default).
- Pulses shorter than FILTER_LEN+1 cycles are rejected.
- Maximum accepted transition rate is one per FILTER_LEN+1 cycles.
- First SPEED_VALID occurs at cycle WINDOW-1 after reset release, then every WINDOW cycles.
- Asserting RESET_N low mid-operation clears all state immediately. After release the block re-enters INIT.
- All outputs are registered. No combinational path from pins to outputs.

## Structure
- Package quadec_pkg holds:
  - the 2-bit phase type;
  - the forward-successor function/constants (00→01, 01→11, 11→10, 10→00);
  - the step encoding (NONE, FWD, REV, ILLEGAL).
- Sub-module quad_filter_v: 2-bit synchronizer plus run-length filter, parameter FILTER_LEN, one instance.
- Top level contains the decode FSM, COUNT/ERR logic and the speed window.

## Test plan
- Forward sweep: reset with pins 00, then drive the sequence 01,11,10,00 ×10, holding each for 8 cycles → COUNT=40, DIR=1, 40 STEP pulses, each arriving 6 cycles after its pin change.
- Reverse plus wrap: from COUNT=0, drive 3 reverse transitions → COUNT=0xFFFFFFFD and DIR=0. Then 5 forward transitions → COUNT=2.
- Glitch and illegal transition:
  - A 3-cycle A pulse → no step.
  - A jump 00→11 held 8 cycles → ERROR=1, ERR_CNT=1, COUNT unchanged.
  - 300 illegal jumps → ERR_CNT=255.
- Reset seeding: hold pins at 11 through reset release → no step and COUNT=0. A following 11→10 → COUNT=1.
- Speed with WINDOW=100: a forward transition every 10 cycles → SPEED=10 with SPEED_VALID at cycles 99, 199, … A simultaneous CLEAR and step → COUNT=0 while SPEED is unaffected.
